// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART RX controller and the bus layer.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module uart_rx_fifo #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    input  logic              iUART_RX_STOP,
    input  logic [7:0]        iser2par,
    input  logic              iRD_EN,
    input  logic              iOVR_CLR,
    output logic [7:0]        oRD_DATA,
    output logic              oRD_VALID,
    output logic              oEMPTY,
    output logic              oFULL,
    output logic [ADDR_W:0]   oLEVEL,
    output logic              oOVERRUN
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              ovr_q, ovr_d;
    logic              empty, full;
    logic              wr_acc, rd_acc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    always_comb begin
        rd_acc   = iRD_EN & ~empty;
        // A pop in the same cycle frees a slot, so a full FIFO still takes the byte.
        wr_acc   = iUART_RX_STOP & (~full | rd_acc);
        wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, wr_acc};
        rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, rd_acc};
        level_d  = wr_ptr_d - rd_ptr_d;
        ovr_d    = ovr_q;
        if (iOVR_CLR) begin
            ovr_d = 1'b0;
        end
        if (iUART_RX_STOP & ~wr_acc) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovr_q    <= ovr_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr_acc) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= iser2par;
        end
    end

`ifdef UART_RX_FIFO_FWFT_EN
    assign oRD_DATA  = mem[rd_ptr_q[ADDR_W-1:0]];
    assign oRD_VALID = ~empty;
`else
    logic [7:0] rd_data_q;
    logic       rd_valid_q;

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
            end
        end
    end

    assign oRD_DATA  = rd_data_q;
    assign oRD_VALID = rd_valid_q;
`endif

    assign oEMPTY   = empty;
    assign oFULL    = full;
    assign oLEVEL   = level_q;
    assign oOVERRUN = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       iCLK = 1'b0;
    logic       iRESETn = 1'b0;
    logic       iUART_RX_STOP = 1'b0;
    logic [7:0] iser2par = 8'h00;
    logic       iRD_EN = 1'b0;
    logic       iOVR_CLR = 1'b0;
    logic [7:0] oRD_DATA;
    logic       oRD_VALID;
    logic       oEMPTY;
    logic       oFULL;
    logic [4:0] oLEVEL;
    logic       oOVERRUN;

    int tests = 0;
    int fails = 0;

    uart_rx_fifo #(.ADDR_W(4)) dut (
        .iCLK          (iCLK),
        .iRESETn       (iRESETn),
        .iUART_RX_STOP (iUART_RX_STOP),
        .iser2par      (iser2par),
        .iRD_EN        (iRD_EN),
        .iOVR_CLR      (iOVR_CLR),
        .oRD_DATA      (oRD_DATA),
        .oRD_VALID     (oRD_VALID),
        .oEMPTY        (oEMPTY),
        .oFULL         (oFULL),
        .oLEVEL        (oLEVEL),
        .oOVERRUN      (oOVERRUN)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, read result as last popped byte.
    logic [7:0] m_q [$];
    logic       m_ovr = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;

    always @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            m_q.delete();
            m_ovr   = 1'b0;
            m_valid = 1'b0;
            m_data  = 8'h00;
        end else begin
            automatic bit rd = iRD_EN && (m_q.size() > 0);
            automatic bit wr = iUART_RX_STOP && ((m_q.size() < DEPTH) || rd);
            m_valid = rd;
            if (rd) m_data = m_q.pop_front();
            if (wr) m_q.push_back(iser2par);
            if (iUART_RX_STOP && !wr) m_ovr = 1'b1;
            else if (iOVR_CLR) m_ovr = 1'b0;
        end
    end

    always @(negedge iCLK) begin
        check("level", 32'(oLEVEL), 32'(m_q.size()));
        check("empty", 32'(oEMPTY), 32'(m_q.size() == 0));
        check("full", 32'(oFULL), 32'(m_q.size() == DEPTH));
        check("overrun", 32'(oOVERRUN), 32'(m_ovr));
`ifdef UART_RX_FIFO_FWFT_EN
        check("rd_valid", 32'(oRD_VALID), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check("rd_data", 32'(oRD_DATA), 32'(m_q[0]));
`else
        check("rd_valid", 32'(oRD_VALID), 32'(m_valid));
        check("rd_data", 32'(oRD_DATA), 32'(m_data));
`endif
    end

    task automatic step(input logic stop, input logic [7:0] d, input logic rd, input logic clr);
        iUART_RX_STOP = stop;
        iser2par      = d;
        iRD_EN        = rd;
        iOVR_CLR      = clr;
        @(posedge iCLK);
        @(negedge iCLK);
        iUART_RX_STOP = 1'b0;
        iRD_EN        = 1'b0;
        iOVR_CLR      = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] ord [3];
        ord[0] = 8'h55; ord[1] = 8'hA3; ord[2] = 8'h0F;

        repeat (2) @(negedge iCLK);
        iRESETn = 1'b1;
        @(negedge iCLK);
        check("lit_reset_empty", 32'(oEMPTY), 32'd1);
        check("lit_reset_level", 32'(oLEVEL), 32'd0);

        // Ordering
        for (int i = 0; i < 3; i++) wr(ord[i]);
        check("lit_level3", 32'(oLEVEL), 32'd3);
        for (int i = 0; i < 3; i++) begin
            rd();
`ifndef UART_RX_FIFO_FWFT_EN
            check("lit_order_data", 32'(oRD_DATA), 32'(ord[i]));
            check("lit_order_valid", 32'(oRD_VALID), 32'd1);
`endif
            check("lit_order_level", 32'(oLEVEL), 32'(2 - i));
        end
        check("lit_order_empty", 32'(oEMPTY), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("lit_valid_drop", 32'(oRD_VALID), 32'd0);

        // Fill, overflow, clear, simultaneous at full, drain
        for (int i = 0; i < DEPTH; i++) wr(8'(i));
        check("lit_full", 32'(oFULL), 32'd1);
        check("lit_level16", 32'(oLEVEL), 32'd16);
        wr(8'hFF);
        check("lit_ovr_set", 32'(oOVERRUN), 32'd1);
        check("lit_ovr_level", 32'(oLEVEL), 32'd16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("lit_ovr_clr", 32'(oOVERRUN), 32'd0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check("lit_simul_full_level", 32'(oLEVEL), 32'd16);
        check("lit_simul_full_ovr", 32'(oOVERRUN), 32'd0);
        for (int i = 0; i < DEPTH; i++) rd();
`ifndef UART_RX_FIFO_FWFT_EN
        check("lit_last_drained", 32'(oRD_DATA), 32'hAA);
`endif
        check("lit_drained_empty", 32'(oEMPTY), 32'd1);

        // Simultaneous at empty: read ignored
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        check("lit_simul_empty_level", 32'(oLEVEL), 32'd1);
`ifndef UART_RX_FIFO_FWFT_EN
        check("lit_simul_empty_valid", 32'(oRD_VALID), 32'd0);
`endif
        rd();

        // Overflow with clear in the same cycle: set wins
        for (int i = 0; i < DEPTH; i++) wr(8'(8'hC0 + i));
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        check("lit_ovr_set_wins", 32'(oOVERRUN), 32'd1);
        for (int i = 0; i < DEPTH; i++) rd();
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Underflow
        rd();
        check("lit_underflow_valid", 32'(oRD_VALID), 32'd0);
        check("lit_underflow_level", 32'(oLEVEL), 32'd0);

        // Wrap-around with random data and some back-to-back traffic
        for (int i = 0; i < 5; i++) wr(8'($urandom_range(0, 255)));
        for (int i = 0; i < 40; i++) begin
            wr(8'($urandom_range(0, 255)));
            if (i % 4 == 3) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            rd();
        end
        while (!oEMPTY && tests < 100000) rd();
        check("lit_wrap_empty", 32'(oEMPTY), 32'd1);

`ifdef UART_RX_FIFO_FWFT_EN
        wr(8'h7E);
        check("lit_fwft_valid", 32'(oRD_VALID), 32'd1);
        check("lit_fwft_data", 32'(oRD_DATA), 32'h7E);
        rd();
        check("lit_fwft_empty", 32'(oEMPTY), 32'd1);
`endif

        // Asynchronous reset mid-traffic at level 5
        for (int i = 0; i < 5; i++) wr(8'(8'h90 + i));
        rd();
        wr(8'h99);
        check("lit_pre_reset_level", 32'(oLEVEL), 32'd5);
        #2 iRESETn = 1'b0;
        #1;
        check("lit_rst_level", 32'(oLEVEL), 32'd0);
        check("lit_rst_empty", 32'(oEMPTY), 32'd1);
        check("lit_rst_full", 32'(oFULL), 32'd0);
        check("lit_rst_ovr", 32'(oOVERRUN), 32'd0);
        check("lit_rst_valid", 32'(oRD_VALID), 32'd0);
`ifndef UART_RX_FIFO_FWFT_EN
        check("lit_rst_data", 32'(oRD_DATA), 32'd0);
`endif
        @(negedge iCLK);
        iRESETn = 1'b1;
        @(negedge iCLK);
        check("lit_post_rst_empty", 32'(oEMPTY), 32'd1);
        rd();
        check("lit_post_rst_valid", 32'(oRD_VALID), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART RX controller. Captures each completed byte, presented with a one-cycle stop strobe, into a circular FIFO. Offers a pop interface to the register/APB layer with level, full/empty and sticky overrun status. Decouples byte arrival at baud rate from bus reads.

## Interface
- `ADDR_W`, default 4: pointer width; FIFO depth = 2**ADDR_W (16 entries).
- `iCLK`, input, 1: system clock; all logic on rising edge.
- `iRESETn`, input, 1: reset, asynchronous, active-low.
- `iUART_RX_STOP`, input, 1: one-cycle write strobe from the RX controller; byte complete.
- `iser2par`, input, 8: received byte; valid only in the cycle `iUART_RX_STOP`=1.
- `iRD_EN`, input, 1: pop request from the bus side.
- `iOVR_CLR`, input, 1: clears `oOVERRUN`.
- `oRD_DATA`, output, 8: popped/head byte.
- `oRD_VALID`, output, 1: `oRD_DATA` qualifier.
- `oEMPTY`, output, 1: level == 0.
- `oFULL`, output, 1: level == 2**ADDR_W.
- `oLEVEL`, output, ADDR_W+1: number of stored bytes, 0..2**ADDR_W.
- `oOVERRUN`, output, 1: sticky; a byte was dropped because the FIFO was full.

## Operation
- Storage: 2**ADDR_W x 8 array, not reset.
- Pointers: write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_W+1 bits. The index is the low ADDR_W bits; the MSB is the wrap bit.
- Empty when the pointers are equal. Full when the index bits are equal and the MSBs differ.
- `oLEVEL` = `wr_ptr` − `rd_ptr`, modulo 2**(ADDR_W+1), registered.
- Write accepted: `iUART_RX_STOP` & (!`oFULL` | read accepted this cycle). On accept, `iser2par` is stored at `wr_ptr` and `wr_ptr` increments, wrapping naturally.
- Read accepted: `iRD_EN` & !`oEMPTY`. On accept, `rd_ptr` increments.
- Simultaneous write and read when full: both are accepted; level stays 2**ADDR_W; no overrun.
- Simultaneous write and read when empty: the read is ignored (underflow); the write is accepted; level becomes 1.
- Overflow (write strobe while full, no read): the byte is dropped, pointers are unchanged, and `oOVERRUN` is set.
- If overflow and `iOVR_CLR` occur in the same cycle, set wins.
- Underflow (`iRD_EN` while empty): no pointer or level change, `oRD_VALID` stays 0, no error flag.
- Reset, including mid-operation, discards contents.
- Reset values: pointers 0, `oLEVEL`=0, `oEMPTY`=1, `oFULL`=0, `oOVERRUN`=0, `oRD_DATA`=0, `oRD_VALID`=0.
- Control is pointer-based; there is no separate FSM. The implicit states are EMPTY, PARTIAL and FULL, with transitions driven by accepted write/read.
  - EMPTY → PARTIAL on write.
  - PARTIAL → FULL when a write brings level to 2**ADDR_W.
  - FULL → PARTIAL on a read without a write.
  - PARTIAL → EMPTY when a read brings level to 0.

## Timing
- Write strobe sampled at edge N: `oEMPTY`, `oFULL` and `oLEVEL` reflect the write after edge N.
- Default read mode (macro undefined):
  - `iRD_EN` accepted at edge N.
  - `oRD_DATA` is loaded at edge N and `oRD_VALID`=1 for exactly the cycle after N.
  - `oRD_DATA` holds its value until the next accepted read.
  - Read latency is 1 cycle.
- Back-to-back reads, one per cycle, are supported; `oRD_VALID` stays high continuously.
- Minimum write-to-read-data latency: strobe at edge N, read at N+1, data valid after N+1.
- Status flags are registered or derived from registered pointers only; no input-to-output combinational path except in FWFT mode (see Configuration).

## Configuration
- Macro: `UART_RX_FIFO_FWFT_EN`.
- Undefined: registered-read mode as described in Timing.
- Defined: first-word-fall-through mode.
  - `oRD_DATA` = mem[`rd_ptr`] combinationally.
  - `oRD_VALID` = !`oEMPTY`.
  - `iRD_EN` acknowledges and pops the current head.
  - The next head appears the cycle after the pop.
  - A byte written into an empty FIFO is visible on `oRD_DATA` with `oRD_VALID`=1 the cycle after the strobe edge.
  - `oRD_DATA` is don't-care while `oEMPTY`=1.
- All other behaviour (pointers, flags, overrun, reset) is identical in both modes.

## Test plan
- Reset: assert `iRESETn`=0 mid-traffic with level 5 → all outputs at reset values immediately; after release, `oEMPTY`=1 and `oLEVEL`=0; a subsequent read yields no `oRD_VALID`.
- Ordering: write 0x55, 0xA3, 0x0F, then pop 3 → `oRD_DATA` sequence 0x55, 0xA3, 0x0F, each with a one-cycle `oRD_VALID`; `oLEVEL` steps 3→2→1→0; `oEMPTY`=1 at end.
- Full/overrun:
  - Write 16 bytes 0x00..0x0F → `oFULL`=1, `oLEVEL`=16.
  - 17th write 0xFF → dropped, `oOVERRUN`=1.
  - Drain → 0x00..0x0F, no 0xFF.
  - `iOVR_CLR` → `oOVERRUN`=0.
- Simultaneous events:
  - Write and read together at full → level stays 16, no overrun, the new byte is read last.
  - Write and read together at empty → level 1, no `oRD_VALID`.
  - `iOVR_CLR` in the same cycle as an overflow → `oOVERRUN`=1.
- Wrap-around: 40 interleaved write/read pairs with random bytes → data matches the scoreboard across 2+ pointer wraps; `oLEVEL` never exceeds 16.
- FWFT build (`UART_RX_FIFO_FWFT_EN` defined):
  - Write 0x7E into empty → next cycle `oRD_VALID`=1, `oRD_DATA`=0x7E without `iRD_EN`.
  - Pop → `oEMPTY`=1.
